// File: rtl/prng_pkg.sv
// Shared xorshift32 constants, forward step and the per-frame result record for the
// PRNG stream checker.
package prng_pkg;

  localparam int unsigned XS_A          = 13;
  localparam int unsigned XS_B          = 17;
  localparam int unsigned XS_C          = 5;
  localparam int unsigned FRAME_LEN_DEF = 256;

  typedef struct packed {
    logic [31:0] seed;
    logic [8:0]  err_cnt;
    logic [7:0]  first_err_idx;
    logic        pass;
    logic        timeout;
  } result_t;

  function automatic logic [31:0] xorshift32_fwd(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << XS_A);
    y = y ^ (y >> XS_B);
    y = y ^ (y << XS_C);
    return y;
  endfunction

endpackage

// File: rtl/prng_stream_checker_if.sv
// Stream-in / result-out bundle between a PRNG word source and the stream checker.
interface prng_stream_checker_if;

  logic        in_valid;
  logic [31:0] rand_num;
  logic        out_valid;
  logic [31:0] seed_out;
  logic [8:0]  err_cnt;
  logic [7:0]  first_err_idx;
  logic        pass;
  logic        timeout;

  modport master (
    output in_valid, rand_num,
    input  out_valid, seed_out, err_cnt, first_err_idx, pass, timeout
  );

  modport slave (
    input  in_valid, rand_num,
    output out_valid, seed_out, err_cnt, first_err_idx, pass, timeout
  );

endinterface

// File: rtl/xorshift32_inv.sv
// Combinational inverse of one xorshift32 (13/17/5) step: recovers x from y = fwd(x).
module xorshift32_inv
  import prng_pkg::*;
(
  input  logic [31:0] y_i,
  output logic [31:0] x_o
);

  logic [31:0] undo_c;
  logic [31:0] undo_b;

  always_comb begin
    // A left xorshift by s is undone by xoring in every multiple of s below 32.
    undo_c = '0;
    for (int k = 0; k <= 31 / int'(XS_C); k++) begin
      undo_c = undo_c ^ (y_i << (k * int'(XS_C)));
    end
    undo_b = undo_c ^ (undo_c >> XS_B);
    x_o = '0;
    for (int k = 0; k <= 31 / int'(XS_A); k++) begin
      x_o = x_o ^ (undo_b << (k * int'(XS_A)));
    end
  end

endmodule

// File: rtl/prng_stream_checker.sv
// Checks framed xorshift32 streams: recovers the seed from word 0, predicts the rest and
// reports one result record per frame (or per gap timeout).
module prng_stream_checker
  import prng_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  prng_stream_checker_if.slave  strm
);

  localparam int unsigned IdxW = $clog2(FRAME_LEN);
  localparam int unsigned GapW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [31:0]     seed_q, seed_d;
  logic [31:0]     exp_q, exp_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [8:0]      errs_q, errs_d;
  logic [7:0]      first_q, first_d;
  logic [GapW-1:0] gap_q, gap_d;
  result_t         res_q, res_d;
  logic            out_valid_q, out_valid_d;

  logic [31:0] seed_inv;
  logic [7:0]  idx_lo;

  xorshift32_inv u_inv (
    .y_i (strm.rand_num),
    .x_o (seed_inv)
  );

  assign idx_lo = 8'(idx_q);

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    exp_d       = exp_q;
    idx_d       = idx_q;
    errs_d      = errs_q;
    first_d     = first_q;
    gap_d       = gap_q;
    res_d       = res_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (strm.in_valid) begin
          seed_d  = seed_inv;
          exp_d   = xorshift32_fwd(strm.rand_num);
          idx_d   = IdxW'(1);
          errs_d  = '0;
          first_d = '0;
          gap_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (strm.in_valid) begin
          // Step from the prediction so a single corrupted word costs exactly one error.
          exp_d = xorshift32_fwd(exp_q);
          idx_d = idx_q + IdxW'(1);
          gap_d = '0;
          if (strm.rand_num != exp_q) begin
            if (errs_q != '1) errs_d = errs_q + 9'd1;
            if (errs_q == '0) first_d = idx_lo;
          end
          if (idx_q == IdxW'(FRAME_LEN - 1)) begin
            state_d             = StIdle;
            out_valid_d         = 1'b1;
            res_d.seed          = seed_q;
            res_d.err_cnt       = errs_d;
            res_d.first_err_idx = first_d;
            res_d.pass          = (errs_d == '0);
            res_d.timeout       = 1'b0;
          end
        end else if (gap_q == GapW'(TIMEOUT - 1)) begin
          state_d             = StIdle;
          out_valid_d         = 1'b1;
          res_d.seed          = seed_q;
          res_d.err_cnt       = errs_q;
          res_d.first_err_idx = first_q;
          res_d.pass          = 1'b0;
          res_d.timeout       = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      seed_q      <= '0;
      exp_q       <= '0;
      idx_q       <= '0;
      errs_q      <= '0;
      first_q     <= '0;
      gap_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      exp_q       <= exp_d;
      idx_q       <= idx_d;
      errs_q      <= errs_d;
      first_q     <= first_d;
      gap_q       <= gap_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign strm.out_valid     = out_valid_q;
  assign strm.seed_out      = res_q.seed;
  assign strm.err_cnt       = res_q.err_cnt;
  assign strm.first_err_idx = res_q.first_err_idx;
  assign strm.pass          = res_q.pass;
  assign strm.timeout       = res_q.timeout;

endmodule
